// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: state encoding, default widths and timeout fill value for the SDRAM host bridge
package sdram_bridge_pkg;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADDR_W      = 24;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_RD   = 2'd3
  } state_e;
endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous request FIFO with push/pop/full/empty/level, head visible combinationally
module sdram_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
  // Storage needs no reset; only entries below level_q are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/sdram_host_bridge.sv
// sdram_host_bridge: queues host read/write requests and sequences them one at a time into sdram_controller.
// SDRAM_BRIDGE_TIMEOUT_EN adds a sticky err_timeout output and a watchdog that aborts stuck transactions.
module sdram_host_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [ADDR_W-1:0]             ctrl_addr,
  output logic [DATA_W-1:0]             ctrl_wdata,
  output logic                          ctrl_wr_enable,
  output logic                          ctrl_rd_enable,
  input  logic                          ctrl_busy,
  input  logic [DATA_W-1:0]             ctrl_rd_data,
  input  logic                          ctrl_rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  , output logic                        err_timeout
`endif
);
  localparam int EW = 1 + ADDR_W + DATA_W;
  logic [EW-1:0]     head;
  logic              empty, full;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  state_e            state_q;
  logic              wr_en_q, rd_en_q, is_rd_q, rd_seen_q, rsp_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rsp_data_q;
  logic              issue, rd_cap, tmo;
  sdram_req_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid),
    .pop_i   (issue),
    .din_i   ({req_we, req_addr, req_wdata}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  assign {head_we, head_addr, head_wdata} = head;
  // A read may only start once the single response slot is free or being freed this cycle.
  assign issue  = state_q == ST_IDLE && !empty && !ctrl_busy && (head_we || !rsp_valid_q || rsp_ready);
  assign rd_cap = ctrl_rd_ready && is_rd_q && !rd_seen_q && state_q != ST_IDLE;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign tmo         = state_q != ST_IDLE && cnt_q == CW'(TIMEOUT_CYC - 1);
  assign err_timeout = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_IDLE || tmo) ? '0 : cnt_q + CW'(1);
      err_q <= err_q | tmo;
    end
  end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      rd_seen_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      if (rd_cap) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= ctrl_rd_data;
        rd_seen_q   <= 1'b1;
      end
      if (tmo) begin
        state_q <= ST_IDLE;
        wr_en_q <= 1'b0;
        rd_en_q <= 1'b0;
        if (is_rd_q && !rd_seen_q && !rd_cap) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= DATA_W'(TIMEOUT_FILL);
        end
      end else begin
        case (state_q)
          ST_IDLE: if (issue) begin
            state_q   <= ST_REQ;
            addr_q    <= head_addr;
            wdata_q   <= head_wdata;
            is_rd_q   <= !head_we;
            wr_en_q   <= head_we;
            rd_en_q   <= !head_we;
            rd_seen_q <= 1'b0;
          end
          ST_REQ: if (ctrl_busy) begin
            state_q <= ST_WAIT_BUSY;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
          end
          ST_WAIT_BUSY: if (!ctrl_busy) state_q <= (is_rd_q && !rd_seen_q && !rd_cap) ? ST_WAIT_RD : ST_IDLE;
          ST_WAIT_RD: if (ctrl_rd_ready) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
  assign req_ready      = !full;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign ctrl_addr      = addr_q;
  assign ctrl_wdata     = wdata_q;
  assign ctrl_wr_enable = wr_en_q;
  assign ctrl_rd_enable = rd_en_q;
  assign idle           = empty && state_q == ST_IDLE && !rsp_valid_q;
endmodule

// File: tb/tb_sdram_host_bridge.sv
// tb_sdram_host_bridge: scoreboard bench for sdram_host_bridge with a behavioural controller model.
// Build with SDRAM_BRIDGE_TIMEOUT_EN to also exercise the watchdog.
module tb_sdram_host_bridge;
  import sdram_bridge_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [23:0] req_addr, ctrl_addr;
  logic [15:0] req_wdata, rsp_data, ctrl_wdata;
  logic        ctrl_wr_enable, ctrl_rd_enable;
  logic        ctrl_busy = 1'b1, ctrl_rd_ready = 1'b0;
  logic [15:0] ctrl_rd_data = '0;
  logic [2:0]  fifo_level;
  logic        idle;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  logic        err_timeout;
`endif
  always #5 clk = ~clk;
  sdram_host_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_wr_enable(ctrl_wr_enable), .ctrl_rd_enable(ctrl_rd_enable),
    .ctrl_busy(ctrl_busy), .ctrl_rd_data(ctrl_rd_data), .ctrl_rd_ready(ctrl_rd_ready),
    .fifo_level(fifo_level), .idle(idle)
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );
  int n_chk = 0, n_pass = 0;
  logic [40:0] cmd_q[$];
  logic [15:0] rsp_q[$];
  logic [15:0] mem [logic [23:0]];
  int  init_left = 100, busy_left = 0, rdy_left = 0, rd_en_cycles = 0;
  bit  hold_busy = 0, hang = 0, early_rdy = 0, m_rd = 0, win = 0, saw_wait_rd = 0;
  logic [23:0] m_addr;
  logic [40:0] m_got, m_exp;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [15:0] rd_val(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 16'hbbbb;
  endfunction
  // Controller model: busy for 3 cycles per command, rd_ready 4 cycles after busy falls (or inside busy when early_rdy).
  always @(negedge clk) begin
    ctrl_rd_ready = 1'b0;
    if (!rst_n) begin
      ctrl_busy = init_left > 0;
      busy_left = 0;
      rdy_left  = 0;
    end else if (init_left > 0) begin
      init_left--;
      ctrl_busy = init_left > 0;
    end else if (hold_busy) ctrl_busy = 1'b1;
    else if (busy_left > 0) begin
      busy_left--;
      if (early_rdy && m_rd && busy_left == 1) begin
        ctrl_rd_ready = 1'b1;
        ctrl_rd_data  = rd_val(m_addr);
      end
      if (busy_left == 0) begin
        ctrl_busy = 1'b0;
        if (m_rd && !early_rdy) rdy_left = 4;
      end
    end else if (rdy_left > 0) begin
      rdy_left--;
      if (rdy_left == 0) begin
        ctrl_rd_ready = 1'b1;
        ctrl_rd_data  = rd_val(m_addr);
      end
    end else begin
      ctrl_busy = 1'b0;
      if ((ctrl_wr_enable || ctrl_rd_enable) && !hang) begin
        check("one_enable", ctrl_wr_enable & ctrl_rd_enable, 0);
        m_got = {ctrl_wr_enable, ctrl_addr, ctrl_wr_enable ? ctrl_wdata : 16'h0};
        if (cmd_q.size() == 0) check("cmd_unexpected", cmd_q.size(), 1);
        else begin
          m_exp = cmd_q.pop_front();
          check("cmd", m_got, m_exp);
        end
        if (ctrl_wr_enable) mem[ctrl_addr] = ctrl_wdata;
        m_rd      = ctrl_rd_enable;
        m_addr    = ctrl_addr;
        ctrl_busy = 1'b1;
        busy_left = 3;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", rsp_q.size(), 1);
      else check("rsp_data", rsp_data, rsp_q.pop_front());
    end
    if (win && ctrl_rd_enable) rd_en_cycles++;
    if (dut.state_q == ST_WAIT_RD) saw_wait_rd = 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 500) begin tick; n++; end
    check("push_ready", req_ready, 1);
    tick;
    cmd_q.push_back({we, a, we ? d : 16'h0});
    if (!we) rsp_q.push_back(d);
    req_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    tick;
    while (!(idle && cmd_q.size() == 0 && rsp_q.size() == 0) && n < 400) begin tick; n++; end
    check({tag, "_idle"}, idle, 1);
  endtask
  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin tick; n++; end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
  endtask
  initial begin
    int n;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1;
    repeat (3) tick;
    check("rst_idle", idle, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_enables", {ctrl_wr_enable, ctrl_rd_enable}, 0);
    rst_n = 1;
    push(1, 24'hfedbed, 16'd3333);
    repeat (10) tick;
    check("init_no_issue", ctrl_wr_enable, 0);
    check("init_queued", fifo_level, 1);
    wait_idle("write");
    check("wr_addr_hold", ctrl_addr, 24'hfedbed);
    check("wr_data_hold", ctrl_wdata, 16'h0d05);
    push(1, 24'h000010, 16'h1234);
    tick;
    check("turnaround_en", ctrl_wr_enable, 1);
    wait_idle("turnaround");
    rsp_ready = 0;
    push(0, 24'hbedfed, 16'hbbbb);
    wait_rsp("read", 100);
    repeat (5) tick;
    check("rsp_held", rsp_valid, 1);
    check("rsp_stable", rsp_data, 16'hbbbb);
    rsp_ready = 1;
    tick;
    check("rsp_cleared", rsp_valid, 0);
    wait_idle("read");
    hold_busy = 1;
    tick; tick;
    for (int i = 0; i < 4; i++) push(1, 24'(i), 16'(16'h100 + i));
    check("b2b_level", fifo_level, 4);
    check("b2b_not_ready", req_ready, 0);
    hold_busy = 0;
    push(1, 24'h4, 16'h104);
    wait_idle("b2b");
    rsp_ready = 0;
    push(0, 24'h1, 16'h101);
    push(0, 24'hfedbed, 16'd3333);
    wait_rsp("bp_first", 100);
    rd_en_cycles = 0; win = 1;
    repeat (30) tick;
    win = 0;
    check("bp_no_second_issue", rd_en_cycles, 0);
    check("bp_level", fifo_level, 1);
    rsp_ready = 1;
    wait_idle("bp");
    early_rdy = 1; saw_wait_rd = 0;
    push(0, 24'h2, 16'h102);
    wait_idle("early");
    early_rdy = 0;
    check("early_no_wait_rd", saw_wait_rd, 0);
    push(0, 24'h3, 16'h103);
    push(1, 24'h20, 16'h0055);
    push(1, 24'h21, 16'h0066);
    n = 0;
    while (dut.state_q != ST_WAIT_BUSY && n < 50) begin tick; n++; end
    check("mid_state", dut.state_q, ST_WAIT_BUSY);
    check("mid_level", fifo_level, 2);
    rst_n = 0;
    #1;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_enables", {ctrl_wr_enable, ctrl_rd_enable}, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_idle", idle, 1);
    cmd_q.delete();
    rsp_q.delete();
    repeat (2) tick;
    rst_n = 1;
    tick;
    push(1, 24'h30, 16'h7777);
    push(0, 24'h30, 16'h7777);
    wait_idle("post_rst");
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    check("tmo_clear", err_timeout, 0);
    hang = 1;
    push(0, 24'h40, 16'hDEAD);
    wait_rsp("tmo", 1200);
    check("tmo_err", err_timeout, 1);
    check("tmo_fill", rsp_data, 16'hDEAD);
    tick;
    cmd_q.delete();
    hang = 0;
    wait_idle("tmo");
    check("tmo_sticky", err_timeout, 1);
`endif
    check("cmd_q_drained", cmd_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/sdram_host_bridge.md
Name: sdram_host_bridge

Overview:
- Host-side request queue and sequencer directly upstream of sdram_controller; drives its wr_addr/wr_data/rd_enable/wr_enable and consumes busy/rd_data/rd_ready.
- Accepts read/write requests on a valid/ready interface and buffers them in a FIFO.
- Issues one request at a time and returns read data on a valid/ready response port.
- Decouples host traffic from controller init and refresh stalls.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2.
- ADDR_W, 24, host address width; matches controller wr_addr.
- DATA_W, 16, data width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with SDRAM_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  host request valid.
- req_ready  out  1  FIFO not full.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  host accepts read data.
- rsp_data  out  DATA_W  read data.
- ctrl_addr  out  ADDR_W  to controller wr_addr; used for both reads and writes.
- ctrl_wdata  out  DATA_W  to controller wr_data.
- ctrl_wr_enable  out  1  to controller wr_enable.
- ctrl_rd_enable  out  1  to controller rd_enable.
- ctrl_busy  in  1  from controller busy.
- ctrl_rd_data  in  DATA_W  from controller rd_data.
- ctrl_rd_ready  in  1  from controller rd_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of queued entries.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset: all outputs 0 except idle = 1 and req_ready = 1. FIFO pointers clear, FSM goes to IDLE, response register is invalid. Reset asserted mid-transaction drops all queued and in-flight requests; enables deassert asynchronously.
- FIFO: push on req_valid && req_ready. Entry is {we, addr, wdata}. Head is popped on the IDLE->REQ transition. Simultaneous push and pop leaves the level unchanged. Push when full is impossible because req_ready = 0. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, REQ, WAIT_BUSY, WAIT_RD.
  - IDLE: FIFO non-empty and ctrl_busy = 0 → latch head into ctrl_addr/ctrl_wdata, pop, go to REQ. For a read, additionally require rsp_valid = 0, or rsp_valid && rsp_ready in the same cycle; otherwise stay in IDLE. Writes are never blocked by a pending response.
  - REQ: hold ctrl_wr_enable or ctrl_rd_enable at 1 (registered, asserted from the first REQ cycle). Go to WAIT_BUSY on the first sampled ctrl_busy = 1. Enable deasserts the cycle after busy is seen.
  - WAIT_BUSY: enables 0. When ctrl_busy = 0: write → IDLE; read with ctrl_rd_ready already seen → IDLE; read otherwise → WAIT_RD.
  - WAIT_RD: wait for ctrl_rd_ready, then IDLE.
- Read capture: ctrl_rd_ready = 1 while a read is in flight (REQ, WAIT_BUSY or WAIT_RD) loads ctrl_rd_data into rsp_data the same edge and sets rsp_valid. The rd_seen flag lets rd_ready arrive before busy falls. rd_ready outside a read is ignored.
- Response: rsp_valid holds until rsp_ready; rsp_data is stable while valid. At most one outstanding read.
- Addresses are passed through unmodified; the controller splits bank/row/column. ctrl_addr and ctrl_wdata hold their last values in IDLE.
- Minimum turnaround: request accepted at cycle 0 → enable high at cycle 2 (one cycle of FIFO write, one cycle of IDLE→REQ).
- idle = (fifo_level == 0) && state == IDLE && !rsp_valid.

Optional Feature:
- Macro: SDRAM_BRIDGE_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, sticky, cleared only by reset).
  - A counter runs in REQ, WAIT_BUSY and WAIT_RD. Reaching TIMEOUT_CYC sets err_timeout, drops enables and forces IDLE.
  - A read that times out returns rsp_data = 16'hDEAD with rsp_valid.
- Not defined: no counter, no port; FSM waits indefinitely.

Decomposition:
- Package sdram_bridge_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_REQ = 1, ST_WAIT_BUSY = 2, ST_WAIT_RD = 3;
  - timeout fill value 16'hDEAD;
  - default widths.
- Sub-module sdram_req_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised width and depth. Sequencer FSM lives in the top module.

Test Plan:
- Write: after reset plus controller-model init (busy high ~100 cycles), push we = 1, addr 24'hfedbed, wdata 16'd3333. Expect: no issue while busy; ctrl_wr_enable rises after busy falls, held until busy = 1; ctrl_addr = 24'hfedbed, ctrl_wdata = 16'h0d05; idle returns to 1.
- Read: push we = 0, addr 24'hbedfed; model returns 16'hbbbb with rd_ready 4 cycles after busy. Expect: rsp_valid = 1, rsp_data = 16'hbbbb, held until rsp_ready.
- Back-to-back: push 4 writes with req_valid held (FIFO_DEPTH = 4) plus a 5th. Expect: req_ready = 0 when fifo_level = 4; issue order preserved; addresses 0,1,2,3 seen on ctrl_addr in order.
- Response backpressure: two reads with rsp_ready = 0. Expect: second read not issued (ctrl_rd_enable stays 0) until the first response is taken.
- Early rd_ready: model pulses rd_ready while busy = 1. Expect: data captured, FSM goes WAIT_BUSY → IDLE without entering WAIT_RD.
- Reset mid-read: assert rst_n = 0 during WAIT_BUSY. Expect: enables 0, rsp_valid 0, fifo_level 0 immediately. With SDRAM_BRIDGE_TIMEOUT_EN: busy never asserts → err_timeout = 1 after 1024 cycles, rsp_data = 16'hDEAD.
